ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Main-memory controller sitting directly downstream of the cache control FSM. It accepts the FSM's `rdram`/`wrram` line requests, models a fixed access latency, and moves one full cache line word-by-word between the cache's line bus and a word-wide synchronous memory array. Each completed transfer is signalled with a single-cycle `ram_ack`.

## Interface
Parameters:
- `LINE_AW`, default 6: line address width; memory holds 2^LINE_AW lines.
- `WORD_W`, default 32: memory word width.
- `LINE_WORDS`, default 4: words per line. Must be a power of two and ≥2.
- `LAT`, default 3: access latency in wait cycles, ≥0.

Ports (reset reset, synchronous, active-high; clock clk):
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rdram` in 1: line read (fill) request, level; held by requester until `ram_ack`.
- `wrram` in 1: line write (write-back) request, level; held until `ram_ack`.
- `line_addr` in LINE_AW: line address; sampled only on transaction start.
- `wline` in WORD_W*LINE_WORDS: write line data; word 0 in bits [WORD_W-1:0]; sampled only on transaction start.
- `rline` out WORD_W*LINE_WORDS: read line buffer; same word ordering as `wline`.
- `ram_ack` out 1: one-cycle completion pulse.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT, XFER, ACK.
- IDLE: if `wrram` or `rdram` is high, latch `line_addr`, latch `wline`, and latch op. Write has priority when both are high. Load the wait counter with LAT. Next state is WAIT, or XFER when LAT=0.
- WAIT: decrement the counter each cycle. Go to XFER after LAT cycles.
- XFER, write: beat b = 0..LINE_WORDS-1, one per cycle. Array write of word b at address {line_addr, b}. Go to ACK after the last beat.
- XFER, read: issue read addresses for beats 0..LINE_WORDS-1. The array has 1-cycle read latency. Word b is captured into `rline` slice b on the edge after its address cycle. This needs one extra drain cycle, so XFER lasts LINE_WORDS+1 cycles. All words are in `rline` before ACK.
- ACK: `ram_ack`=1 for exactly one cycle, then IDLE. Requests are not sampled during the ACK cycle.
- Beat counter width is clog2(LINE_WORDS). Word address = {line_addr, beat}, LINE_AW+clog2(LINE_WORDS) bits. No wrap beyond the line.
- `rline` changes only during read XFER. It holds its value across writes and idle.
- Request deasserted mid-transaction: ignored. The transaction completes and acks normally. There is no abort.
- `line_addr`/`wline` changes after start: ignored, because values are latched.
- Reset, including mid-transaction:
  - Next cycle: state IDLE, `ram_ack`=0, `busy`=0, `rline`=0, counters 0.
  - Array words already written stay written. Unwritten beats are not written.
  - Array contents are never cleared by reset. They are zero-initialised at time 0 in simulation.

## Timing
- Request high in IDLE in cycle 0 → `busy` high from cycle 1.
- Write: `ram_ack` high in cycle 1+LAT+LINE_WORDS. Default: cycle 8.
- Read: `ram_ack` high in cycle 2+LAT+LINE_WORDS. Default: cycle 9.
- `rline` is valid in the `ram_ack` cycle and stays stable until the next read transaction.
- Back-to-back: the requester switches `wrram`→`rdram` on the ack edge. The controller is back in IDLE the cycle after ack, and the next transaction starts there. Inter-transaction gap: exactly the IDLE cycle.
- `ram_ack` and `busy` are registered outputs with no combinational path from inputs.

## Structure
- Shared package `cache_pkg`:
  - ram_ctrl state encoding: IDLE=2'b00, WAIT=2'b01, XFER=2'b10, ACK=2'b11.
  - op encoding (OP_RD, OP_WR).
  - Default LINE_AW/WORD_W/LINE_WORDS/LAT constants, shared with the cache datapath.
- Sub-module `ram_array`: single-port synchronous RAM. Signals: `we`, `addr`, `wdata`, `rdata`. Registered read, 1-cycle latency. Depth 2^(LINE_AW+clog2(LINE_WORDS)), WORD_W wide. Write-first behaviour is not required because read and write never share a cycle.
- The top level holds the FSM, wait and beat counters, latches, and the `rline` buffer.

## Test plan
Defaults: LAT=3, LINE_WORDS=4, WORD_W=32.
1. `wrram` line 5, `wline`={32'hD,32'hC,32'hB,32'hA} → `ram_ack` one cycle at cycle 8. Then `rdram` line 5 → `ram_ack` at cycle 9 and `rline`={D,C,B,A}.
2. `wrram` line 2 held; on the ack edge switch to `rdram` line 7 (preloaded {4,3,2,1}). Expect the read to start the cycle after ack, `ram_ack` 9 cycles later, and `rline`={4,3,2,1}. Line 2 reads back as written.
3. `wrram` deasserted in cycle 2 (WAIT) → transaction still completes; `ram_ack` at cycle 8; data written.
4. `reset` in the 2nd XFER beat of a write to line 3 (prior contents 0) → next cycle `busy`=0, `ram_ack`=0, no ack ever. Readback shows words 0–1 new and words 2–3 zero.
5. `rdram` and `wrram` both high, line 1 → write performed, `ram_ack` at cycle 8, `rline` unchanged.
6. LAT=0 instance: `wrram` → `ram_ack` at cycle 5; `rdram` → `ram_ack` at cycle 6 with correct data.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: definitions shared between the cache control FSM, the cache
// datapath and the main-memory controller (ram_ctrl).
// Contents:
//   ram_state_t  - ram_ctrl FSM state encoding
//   ram_op_t     - latched transaction type (line read / line write)
//   DEF_*        - default line geometry and memory latency
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    XFER = 2'b10,
    ACK  = 2'b11
  } ram_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } ram_op_t;

  localparam int DEF_LINE_AW    = 6;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LAT        = 3;

endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: line-request bus between the cache control FSM (master) and
// the main-memory controller (slave).
// Signals:
//   rdram, wrram - level line read / write requests, held until ram_ack
//   line_addr    - line address, sampled at transaction start
//   wline        - write line data, word 0 in the low bits
//   rline        - read line buffer, same word ordering as wline
//   ram_ack      - one-cycle completion pulse
//   busy         - controller not idle
interface ram_ctrl_if
  import cache_pkg::*;
#(
  parameter int LINE_AW    = DEF_LINE_AW,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
);

  logic                         rdram;
  logic                         wrram;
  logic [LINE_AW-1:0]           line_addr;
  logic [WORD_W*LINE_WORDS-1:0] wline;
  logic [WORD_W*LINE_WORDS-1:0] rline;
  logic                         ram_ack;
  logic                         busy;

  modport master (
    output rdram, wrram, line_addr, wline,
    input  rline, ram_ack, busy
  );

  modport slave (
    input  rdram, wrram, line_addr, wline,
    output rline, ram_ack, busy
  );

endinterface

// File: rtl/ram_array.sv
// ram_array: single-port synchronous word RAM with registered read
// (data for the address presented in cycle N appears in cycle N+1).
// Contents are not affected by any reset; they start at zero in simulation.
// Ports:
//   clk   - clock
//   we    - write enable for wdata at addr
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
module ram_array #(
  parameter int AW     = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [0:(1<<AW)-1] = '{default: '0};

  // Array write port.
  always @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port; reads and writes never share a cycle.
  always_ff @(posedge clk) begin
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: main-memory controller below the cache control FSM. Accepts
// line read/write requests, waits LAT cycles, then moves one cache line
// word by word between the line bus and ram_array, finishing with a
// one-cycle ram_ack.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - ram_ctrl_if slave modport (requests, line data, ack, busy)
module ram_ctrl
  import cache_pkg::*;
#(
  parameter int LINE_AW    = DEF_LINE_AW,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LAT        = DEF_LAT
) (
  input logic       clk,
  input logic       reset,
  ram_ctrl_if.slave bus
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int WCW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int AW  = LINE_AW + BW;
  localparam int LW  = WORD_W * LINE_WORDS;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [WCW-1:0] LAT_CNT   = WCW'(LAT);

  ram_state_t         state;
  ram_state_t         state_next;
  ram_op_t            op;
  logic [LINE_AW-1:0] addr_q;
  logic [LW-1:0]      wline_q;
  logic [WCW-1:0]     wcnt;
  logic [BW-1:0]      beat;
  logic               drain;    // all read addresses issued, last word in flight
  logic               rd_vld;   // rdata holds the word addressed last cycle
  logic [BW-1:0]      rd_beat;  // slice that word belongs to
  logic [LW-1:0]      rline_q;
  logic               ack_q;
  logic               busy_q;

  logic               start;
  logic               we;
  logic               rd_issue;
  logic [AW-1:0]      mem_addr;
  logic [WORD_W-1:0]  wdata;
  logic [WORD_W-1:0]  rdata;

  // Next-state decode and array control.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    we         = 1'b0;
    rd_issue   = 1'b0;
    mem_addr   = {addr_q, beat};
    wdata      = wline_q[int'(beat)*WORD_W +: WORD_W];
    case (state)
      IDLE: begin
        if (bus.wrram || bus.rdram) begin
          start      = 1'b1;
          state_next = (LAT == 0) ? XFER : WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        // Counter entered at LAT; leave after the cycle it reads 1.
        if (wcnt <= WCW'(1)) begin
          state_next = XFER;
        end else begin
          state_next = WAIT;
        end
      end
      XFER: begin
        if (op == OP_WR) begin
          we = 1'b1;
          if (beat == LAST_BEAT) begin
            state_next = ACK;
          end else begin
            state_next = XFER;
          end
        end else begin
          if (drain) begin
            state_next = ACK;
          end else begin
            rd_issue   = 1'b1;
            state_next = XFER;
          end
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, counters, request latches and read line buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op      <= OP_RD;
      addr_q  <= '0;
      wline_q <= '0;
      wcnt    <= '0;
      beat    <= '0;
      drain   <= 1'b0;
      rd_vld  <= 1'b0;
      rd_beat <= '0;
      rline_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      busy_q  <= (state_next != IDLE);
      ack_q   <= (state_next == ACK);
      rd_vld  <= rd_issue;
      rd_beat <= beat;
      if (start) begin
        op      <= bus.wrram ? OP_WR : OP_RD;
        addr_q  <= bus.line_addr;
        wline_q <= bus.wline;
        wcnt    <= LAT_CNT;
        beat    <= '0;
        drain   <= 1'b0;
      end else begin
        if (state == WAIT) begin
          wcnt <= wcnt - WCW'(1);
        end
        if (we || rd_issue) begin
          beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
        end
        if (rd_issue && (beat == LAST_BEAT)) begin
          drain <= 1'b1;
        end
      end
      if (rd_vld) begin
        rline_q[int'(rd_beat)*WORD_W +: WORD_W] <= rdata;
      end
    end
  end

  assign bus.rline   = rline_q;
  assign bus.ram_ack = ack_q;
  assign bus.busy    = busy_q;

  ram_array #(
    .AW     (AW),
    .WORD_W (WORD_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (mem_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed bench for ram_ctrl. Two instances share clock and
// reset: u0 with default parameters (LAT=3) and u1 with LAT=0.
// Cycle 0 is the IDLE cycle in which a request is first presented; all
// sampling and driving happens 1 time unit after the rising edge.
module tb_ram_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ram_ctrl_if #(.LINE_AW(6), .WORD_W(32), .LINE_WORDS(4)) bus0 ();
  ram_ctrl_if #(.LINE_AW(6), .WORD_W(32), .LINE_WORDS(4)) bus1 ();

  ram_ctrl #(.LINE_AW(6), .WORD_W(32), .LINE_WORDS(4), .LAT(3)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  ram_ctrl #(.LINE_AW(6), .WORD_W(32), .LINE_WORDS(4), .LAT(0)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           sel;
    logic         rd;
    logic         wr;
    logic [5:0]   line;
    logic [127:0] data;
    int           exp_ack;
    logic         chk_rline;
    logic [127:0] exp_rline;
  } vec_t;

  localparam logic [127:0] L_DCBA = {32'hD, 32'hC, 32'hB, 32'hA};
  localparam logic [127:0] L_4321 = {32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [127:0] L_1F   = {32'h1F1F_0003, 32'h1F1F_0002, 32'h1F1F_0001, 32'h1F1F_0000};
  localparam logic [127:0] L_99   = {32'h9999_DDDD, 32'h9999_CCCC, 32'h9999_BBBB, 32'h9999_AAAA};
  localparam logic [127:0] L_22   = {32'h2222_0004, 32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
  localparam logic [127:0] L_44   = {32'h4444_0004, 32'h4444_0003, 32'h4444_0002, 32'h4444_0001};
  localparam logic [127:0] L_33   = {32'h3333_0004, 32'h3333_0003, 32'h3333_0002, 32'h3333_0001};
  localparam logic [127:0] L_33P  = {32'h0, 32'h0, 32'h3333_0002, 32'h3333_0001};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(int sel, logic rd, logic wr, logic [5:0] line, logic [127:0] data);
    if (sel == 0) begin
      bus0.rdram = rd; bus0.wrram = wr; bus0.line_addr = line; bus0.wline = data;
    end else begin
      bus1.rdram = rd; bus1.wrram = wr; bus1.line_addr = line; bus1.wline = data;
    end
  endtask

  function automatic logic get_ack(int sel);
    return (sel == 0) ? bus0.ram_ack : bus1.ram_ack;
  endfunction

  function automatic logic get_busy(int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic [127:0] get_rline(int sel);
    return (sel == 0) ? bus0.rline : bus1.rline;
  endfunction

  // Advance until ram_ack; returns elapsed cycles or -1 on timeout.
  // busy must be high at cycle busy_at.
  task automatic wait_ack(int sel, int busy_at, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == busy_at) chk_int("busy after start", int'(get_busy(sel)), 1);
      if (get_ack(sel)) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Read back one line on u0 and compare it.
  task automatic readback(string name, logic [5:0] line, logic [127:0] exp);
    int cyc;
    drive(0, 1'b1, 1'b0, line, '0);
    wait_ack(0, 1, cyc);
    drive(0, 1'b0, 1'b0, '0, '0);
    chk_int({name, " ack cycle"}, cyc, 9);
    chk({name, " data"}, get_rline(0), exp);
    step();
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    int acks;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    vecs.push_back('{0, 1'b0, 1'b1, 6'd5, L_DCBA, 8, 1'b0, '0});
    vecs.push_back('{0, 1'b1, 1'b0, 6'd5, '0,     9, 1'b1, L_DCBA});
    vecs.push_back('{0, 1'b0, 1'b1, 6'd7, L_4321, 8, 1'b1, L_DCBA});
    vecs.push_back('{0, 1'b1, 1'b1, 6'd1, L_1F,   8, 1'b1, L_DCBA});
    vecs.push_back('{0, 1'b1, 1'b0, 6'd1, '0,     9, 1'b1, L_1F});
    vecs.push_back('{1, 1'b0, 1'b1, 6'd9, L_99,   5, 1'b0, '0});
    vecs.push_back('{1, 1'b1, 1'b0, 6'd9, '0,     6, 1'b1, L_99});

    step(); step(); step();
    reset = 1'b0;
    step();
    chk("reset busy", 128'(bus0.busy), 128'(0));
    chk("reset ack", 128'(bus0.ram_ack), 128'(0));
    chk("reset rline", bus0.rline, '0);
    chk("reset busy lat0", 128'(bus1.busy), 128'(0));

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].line, vecs[i].data);
      wait_ack(vecs[i].sel, 1, cyc);
      drive(vecs[i].sel, 1'b0, 1'b0, '0, '0);
      chk_int($sformatf("vec%0d ack cycle", i), cyc, vecs[i].exp_ack);
      if (vecs[i].chk_rline) chk($sformatf("vec%0d rline", i), get_rline(vecs[i].sel), vecs[i].exp_rline);
      step();
      chk_int($sformatf("vec%0d ack one cycle", i), int'(get_ack(vecs[i].sel)), 0);
      chk_int($sformatf("vec%0d idle after ack", i), int'(get_busy(vecs[i].sel)), 0);
    end

    // Back-to-back: write line 2, switch to read line 7 on the ack edge.
    // The read's cycle 0 is the IDLE cycle after ack, so its ack arrives
    // 10 cycles after the write ack.
    drive(0, 1'b0, 1'b1, 6'd2, L_22);
    wait_ack(0, 1, cyc);
    chk_int("b2b write ack cycle", cyc, 8);
    drive(0, 1'b1, 1'b0, 6'd7, '0);
    step();
    chk_int("b2b idle gap", int'(bus0.busy), 0);
    wait_ack(0, 1, cyc);
    drive(0, 1'b0, 1'b0, '0, '0);
    chk_int("b2b read ack cycle", cyc, 9);
    chk("b2b read data", bus0.rline, L_4321);
    step();
    readback("b2b line2", 6'd2, L_22);

    // Request dropped during WAIT: the write still completes.
    drive(0, 1'b0, 1'b1, 6'd4, L_44);
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 2) drive(0, 1'b0, 1'b0, 6'd0, '0);
      if (bus0.ram_ack) begin
        cyc = c;
        break;
      end
    end
    chk_int("drop ack cycle", cyc, 8);
    step();
    readback("drop line4", 6'd4, L_44);

    // Reset in the second write beat (cycle 5) of line 3.
    drive(0, 1'b0, 1'b1, 6'd3, L_33);
    for (int c = 1; c <= 5; c++) step();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    step();
    reset = 1'b0;
    chk_int("reset mid busy", int'(bus0.busy), 0);
    chk_int("reset mid ack", int'(bus0.ram_ack), 0);
    chk("reset mid rline", bus0.rline, '0);
    acks = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (bus0.ram_ack) acks++;
    end
    chk_int("no ack after reset", acks, 0);
    readback("partial line3", 6'd3, L_33P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
